// File: rtl/adder_station.sv
// adder_station: reservation station plus fixed-latency add/sub unit on the ROB issue and result buses
module adder_station #(
  parameter int WORD_SIZE = 32,
  parameter int RB_SIZE = 8,
  parameter int RB_INDEX = 4,
  parameter int READY = 15,
  parameter int REG_INDEX = 5,
  parameter int FU_INDEX = 4,
  parameter int FU_ID = 0,
  parameter int ADD_LATENCY = 2,
  parameter logic [3:0] INST_ADD = 4'h0,
  parameter logic [3:0] INST_SUB = 4'h1,
  parameter logic [3:0] INST_ADDI = 4'h5,
  parameter logic [3:0] INST_SUBI = 4'h6
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic [FU_INDEX-1:0]         CDB_inst_fu,
  input  logic [WORD_SIZE-1:0]        CDB_inst_inst,
  input  logic [RB_INDEX-1:0]         CDB_inst_RBindex,
  output logic [REG_INDEX-1:0]        numj,
  output logic [REG_INDEX-1:0]        numk,
  input  logic [WORD_SIZE-1:0]        vj,
  input  logic [WORD_SIZE-1:0]        vk,
  input  logic [RB_INDEX-1:0]         qj,
  input  logic [RB_INDEX-1:0]         qk,
  input  logic [RB_SIZE*WORD_SIZE-1:0] CDB_data_data,
  input  logic [RB_SIZE-1:0]          CDB_data_valid,
  output logic [RB_SIZE*WORD_SIZE-1:0] out_data,
  output logic [RB_SIZE-1:0]          out_valid,
  output logic                        busy
);
  localparam int NL = 2 ** RB_INDEX;
  localparam int DW = RB_SIZE * WORD_SIZE;
  localparam int CW = (ADD_LATENCY > 1) ? $clog2(ADD_LATENCY) : 1;
  localparam logic [RB_INDEX-1:0] RDY = RB_INDEX'(READY);
  localparam logic [FU_INDEX-1:0] MY_FU = FU_INDEX'(FU_ID);
  localparam logic [CW-1:0] LAT1 = CW'(ADD_LATENCY - 1);
  typedef enum logic [1:0] {IDLE, WAIT_OPS, EXEC, BCAST} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic sub_q, sub_d, rj_q, rj_d, rk_q, rk_d;
  logic [RB_INDEX-1:0] tag_q, tag_d, qj_q, qj_d, qk_q, qk_d;
  logic [WORD_SIZE-1:0] vj_q, vj_d, vk_q, vk_d, res_q, res_d;
  logic [NL-1:0] vld_x;
  logic [WORD_SIZE-1:0] lane_ij, lane_ik, lane_wj, lane_wk, imm_v;
  logic issue, is_imm, is_sub, unused_ok;
  assign numj = CDB_inst_inst[22:18];
  assign numk = CDB_inst_inst[17:13];
  assign busy = state_q != IDLE;
  assign issue = CDB_inst_fu == MY_FU;
  assign is_imm = CDB_inst_inst[31:28] == INST_ADDI || CDB_inst_inst[31:28] == INST_SUBI;
  assign is_sub = CDB_inst_inst[31:28] == INST_SUB || CDB_inst_inst[31:28] == INST_SUBI;
  assign imm_v = {{(WORD_SIZE-13){CDB_inst_inst[12]}}, CDB_inst_inst[12:0]};
  assign vld_x = NL'(CDB_data_valid);
  assign lane_ij = WORD_SIZE'(CDB_data_data >> (qj * WORD_SIZE));
  assign lane_ik = WORD_SIZE'(CDB_data_data >> (qk * WORD_SIZE));
  assign lane_wj = WORD_SIZE'(CDB_data_data >> (qj_q * WORD_SIZE));
  assign lane_wk = WORD_SIZE'(CDB_data_data >> (qk_q * WORD_SIZE));
  assign out_valid = (state_q == BCAST) ? RB_SIZE'(NL'(1) << tag_q) : '0;
  assign out_data = (state_q == BCAST) ? DW'(res_q) << (tag_q * WORD_SIZE) : '0;
  assign unused_ok = ^{CDB_inst_inst[27:23], INST_ADD};
  // next-state: accept, operand snooping, latency countdown, broadcast; flush overrides all
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    sub_d = sub_q;
    tag_d = tag_q;
    qj_d = qj_q;
    qk_d = qk_q;
    rj_d = rj_q;
    rk_d = rk_q;
    vj_d = vj_q;
    vk_d = vk_q;
    res_d = res_q;
    case (state_q)
      IDLE: if (issue) begin
        sub_d = is_sub;
        tag_d = CDB_inst_RBindex;
        qj_d = qj;
        qk_d = qk;
        rj_d = qj == RDY || vld_x[qj];
        rk_d = is_imm || qk == RDY || vld_x[qk];
        vj_d = (qj == RDY) ? vj : lane_ij;
        vk_d = is_imm ? imm_v : (qk == RDY) ? vk : lane_ik;
        state_d = (rj_d && rk_d) ? EXEC : WAIT_OPS;
        cnt_d = LAT1;
      end
      WAIT_OPS: begin
        rj_d = rj_q || vld_x[qj_q];
        rk_d = rk_q || vld_x[qk_q];
        vj_d = rj_q ? vj_q : lane_wj;
        vk_d = rk_q ? vk_q : lane_wk;
        state_d = (rj_d && rk_d) ? EXEC : WAIT_OPS;
        cnt_d = LAT1;
      end
      EXEC: begin
        state_d = (cnt_q == '0) ? BCAST : EXEC;
        cnt_d = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
        res_d = (cnt_q == '0) ? (sub_q ? vj_q - vk_q : vj_q + vk_q) : res_q;
      end
      BCAST: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
      cnt_d = '0;
    end
  end
  // state and entry registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      sub_q <= 1'b0;
      tag_q <= '0;
      qj_q <= '0;
      qk_q <= '0;
      rj_q <= 1'b0;
      rk_q <= 1'b0;
      vj_q <= '0;
      vk_q <= '0;
      res_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      sub_q <= sub_d;
      tag_q <= tag_d;
      qj_q <= qj_d;
      qk_q <= qk_d;
      rj_q <= rj_d;
      rk_q <= rk_d;
      vj_q <= vj_d;
      vk_q <= vk_d;
      res_q <= res_d;
    end
  end
  // the ROB must never address this unit while it holds an instruction
  assert property (@(posedge clk) disable iff (reset || flush) !(busy && issue));
endmodule

// File: doc/adder_station.md
# adder_station

Reservation-station-plus-adder functional unit: the receiving end of the reorder buffer's instruction-issue bus (`CDB_inst_*`) and a producer on its result bus (`CDB_data_*`). It accepts one ADD/SUB/ADDI/SUBI instruction when its FU id is addressed. It captures ready operands from the register file/status and snoops `CDB_data` for pending ones, executes with a fixed latency, then broadcasts the result into its instruction's RB slot for one cycle. It reports `busy` so the ROB issues only to free units, and is squashed by the ROB's per-FU branch flush.

## Interface
- WORD_SIZE, 32, datapath width
- RB_SIZE, 8, reorder-buffer slots (result bus has one lane per slot)
- RB_INDEX, 4, RB tag width; RB_SIZE < 2**RB_INDEX
- READY, 15, tag value meaning "operand value already in register file"
- REG_INDEX, 5, register number width
- FU_INDEX, 4, FU id width
- FU_ID, 0, this unit's id on `CDB_inst_fu`
- ADD_LATENCY, 2, execute cycles (>=1)
- INST_ADD/INST_SUB/INST_ADDI/INST_SUBI, 4'h0/4'h1/4'h5/4'h6, opcodes in inst[31:28]

- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- flush  in  1  ROB squash for this FU (its `reset_out[FU_ID]` bit); synchronous, active-high
- CDB_inst_fu  in  FU_INDEX  target FU of the issue bus
- CDB_inst_inst  in  WORD_SIZE  instruction word
- CDB_inst_RBindex  in  RB_INDEX  destination RB slot
- numj, numk  out  REG_INDEX  source register numbers: inst[22:18], inst[17:13] of `CDB_inst_inst` (combinational)
- vj, vk  in  WORD_SIZE  register values for numj/numk
- qj, qk  in  RB_INDEX  producer tags for numj/numk; READY = value valid
- CDB_data_data  in  RB_SIZE*WORD_SIZE  snooped result bus, lane i = bits [i*WORD_SIZE +: WORD_SIZE]
- CDB_data_valid  in  RB_SIZE  snooped lane valids
- out_data  out  RB_SIZE*WORD_SIZE  own result, only own lane nonzero; OR-merged at top level
- out_valid  out  RB_SIZE  own lane valid, one-hot or zero
- busy  out  1  unit occupied

## Operation
- States: IDLE, WAIT_OPS, EXEC, BCAST. `busy` = (state != IDLE).
- Issue accept: state IDLE and CDB_inst_fu == FU_ID at posedge. The entry latches op, RB tag, and for each operand either value (q == READY) or tag.
- Issue while busy: ignored; entry unchanged. This is a protocol violation and must be flagged by an assertion.
- Operand k for ADDI/SUBI: imm = sign-extended inst[12:0]; always ready; qk/vk ignored.
- Issue-cycle forwarding: if q != READY and CDB_data_valid[q] is high at the accepting edge, capture that lane's data as the value.
- WAIT_OPS: each posedge, any pending operand whose tag lane is valid captures the lane data. Both operands may resolve on one edge, from the same or different lanes.
- Transitions:
  - IDLE->EXEC on accept with both operands ready; IDLE->WAIT_OPS otherwise.
  - WAIT_OPS->EXEC on the edge the last operand resolves.
  - EXEC->BCAST when the counter expires.
  - BCAST->IDLE after one cycle.
- Result: ADD/ADDI = j + k, SUB/SUBI = j − k. Modulo 2**WORD_SIZE; no overflow or carry output.
- Result latched at entry to BCAST; value stable throughout BCAST.
- BCAST: out_valid[tag] = 1, out_data lane tag = result; all other lanes 0.
- reset or flush: state IDLE, counter 0, out_valid 0, out_data 0, busy 0.
  - Priority reset > flush > issue/progress. An issue presented on the same edge as flush is dropped.
  - Effective from any state, including mid-EXEC and mid-BCAST.

## Timing
- Reset values: busy 0, out_valid 0, out_data 0. numj/numk follow CDB_inst_inst combinationally.
- Ready operands, accept at edge E:
  - busy high from E.
  - EXEC occupies cycles E..E+ADD_LATENCY−1.
  - out_valid high from edge E+ADD_LATENCY for exactly one cycle.
  - busy and out_valid fall at edge E+ADD_LATENCY+1.
  - A new issue is accepted at that edge or later.
- Waiting operand resolved at edge W: same sequence with W in place of E.
- Total unit occupancy for ready operands: ADD_LATENCY+1 cycles.
- No back-pressure on the result bus: the broadcast cycle is not extended. The ROB and other stations must sample within it.

## Test plan
- Reset then ADD, qj = qk = READY, vj = 5, vk = 7, tag 3, issued at edge 0 → busy at 0; out_valid = 8'b0000_1000 with lane 3 = 12 during cycle 2–3; busy 0 after edge 3.
- SUBI with vj = 3, imm = 13'h1FFB (−5) → result 8. SUB 0 − 1 → 32'hFFFF_FFFF (wrap).
- ADD with qj = 2, vk = 4 ready → remains WAIT_OPS. CDB_data_valid[2] with lane 2 = 10 at edge 5 → EXEC; result 14 broadcast from edge 7.
- Issue with qj = qk = 6 while CDB_data_valid[6] = 1 and lane 6 = 9 on the same edge → forwarded; result 18, no WAIT_OPS cycle.
- flush asserted mid-EXEC and mid-WAIT_OPS → next cycle busy 0, no out_valid ever. Flush coincident with issue → issue dropped.
- Second issue to FU_ID while busy → ignored and assertion fires; the first result is unaltered. A different FU_ID on CDB_inst_fu is never accepted.
